sum_sq_sched: RTL and testbench
===============================

Name: sum_sq_sched

Overview:
- Multi-cycle sum-of-squares engine shared between two requesters.
- Computes S(n) = 1^2 + 2^2 + ... + n^2 for a 4-bit n, one term per clock.
- Uses a single small squarer and an 11-bit accumulator.
- A round-robin scheduler grants the engine to one requester at a time and returns the result with a done pulse tagged with the requester ID.

Parameters:
- N_W, 4, width of each n operand (fixed at 4 in this revision).
- SUM_W, 11, width of the result; S(15)=1240 fits without overflow.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, synchronous, active-high
- req  in  2  level request per requester; held until ack
- n0  in  N_W  operand from requester 0; sampled at ack edge
- n1  in  N_W  operand from requester 1; sampled at ack edge
- ack  out  2  one-hot, one-cycle pulse: request accepted, operand latched
- busy  out  1  engine not IDLE
- done  out  1  one-cycle pulse: sum valid for done_id
- done_id  out  1  requester ID for the current/last result
- sum  out  SUM_W  result; holds its value until the next done

Behaviour:
- Reset: one clock and one reset; reset is synchronous and active-high.
  - On reset: state=IDLE, ack=0, busy=0, done=0, done_id=0, sum=0, pri=0, count=0, acc=0.
  - Reset mid-RUN aborts the job; no done is issued.
- States: IDLE, RUN (2-state FSM, plus registered done/ack pulses).
- IDLE:
  - If any req bit is set at a rising edge, grant it and go to RUN. This edge is E0.
  - Simultaneous requests: grant the requester with index pri.
  - Single request: grant that requester regardless of pri.
  - On grant: ack[id]=1 for the cycle after E0; latch n_lat, id_lat; count=1; acc=0.
- RUN, edges E1..Ek:
  - If n_lat==0: at E1 load sum=0, done=1, done_id=id_lat; return to IDLE.
  - Otherwise each edge computes acc_next = acc + count*count.
    - count*count is 8 bits, zero-extended to SUM_W.
  - When count==n_lat: sum=acc_next, done=1, done_id=id_lat, state=IDLE.
  - Otherwise: acc=acc_next, count=count+1.
- Latency: ack is high in cycle C0; done is high in cycle C_max(n,1). Zero bubble after done:
  - IDLE is active in the same cycle done is high.
  - A pending request is accepted at the following edge.
  - The next ack coincides with the cycle after done.
- Fairness: on every completion (or abort), pri = ~id_lat. A requester waiting while the other is served is granted next, even if the other re-requests.
- req is level-sensitive and is not sampled during RUN.
  - A req dropped before ack is not served.
  - The requester must deassert req in the ack cycle, or it is re-requested.
- busy = (state==RUN); it is high in cycles C0..C_max(n,1)-1.
- Operand inputs n0/n1 are ignored except at the accept edge. Changes during RUN have no effect.
- Arithmetic is unsigned. No overflow is possible for n≤15; no saturation logic.

Optional Feature:
- Macro: SUM_SQ_SCHED_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 at an edge while in RUN: return to IDLE, no done, sum unchanged, pri=~id_lat, count/acc cleared.
  - abort in IDLE is ignored.
  - abort has priority over completion at the same edge.
- Not defined: no abort port; every accepted job runs to completion unless rst is asserted.

Test Plan:
- Reset: hold rst 2 cycles, then release with req=00 → ack=00, busy=0, done=0, done_id=0, sum=0; outputs stable for 10 cycles.
- Single job: req=01, n0=2, drop req on ack → ack=01 at C0; done=1, done_id=0, sum=5 at C2; sum holds at 5 afterwards. Repeat with n0=15 → sum=1240 at C15.
- n=0: req=10, n1=0 → ack=10 at C0; done=1, done_id=1, sum=0 at C1; busy high only in C0.
- Contention: req=11 from reset, n0=4, n1=3 → requester 0 first (sum=30, done at C4). Requester 1 is acked the cycle after done; sum=14, done_id=1, three cycles later.
- Fairness and mid-run reset:
  - req0 held continuously, req1 asserted while job 0 is running → grants alternate 0,1,0.
  - Separately, assert rst during RUN with n=9 → no done, all outputs at reset values next cycle.
- With SUM_SQ_SCHED_ABORT_EN: start n0=10, pulse abort at C3 → no done, sum keeps its previous value, busy=0 next cycle; pending req1 is granted next.

Source files
------------

// File: rtl/sum_sq_sched.sv
// sum_sq_sched: two-requester round-robin sum-of-squares engine.
// Define SUM_SQ_SCHED_ABORT_EN to add the abort input.
module sum_sq_sched #(
  parameter int N_W   = 4,
  parameter int SUM_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [N_W-1:0]   n0,
  input  logic [N_W-1:0]   n1,
`ifdef SUM_SQ_SCHED_ABORT_EN
  input  logic             abort,
`endif
  output logic [1:0]       ack,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [SUM_W-1:0] sum
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, state_nx;
  logic             pri, pri_nx;
  logic             id_lat, id_nx;
  logic [N_W-1:0]   n_lat, n_nx;
  logic [N_W-1:0]   count, count_nx;
  logic [SUM_W-1:0] acc, acc_nx;
  logic [SUM_W-1:0] sum_nx, acc_add;
  logic [2*N_W-1:0] sq;
  logic [1:0]       ack_nx;
  logic             done_nx, done_id_nx;
  logic             gnt_id, kill, last;

`ifdef SUM_SQ_SCHED_ABORT_EN
  assign kill = abort;
`else
  assign kill = 1'b0;
`endif

  assign sq      = {{N_W{1'b0}}, count}
                 * {{N_W{1'b0}}, count};
  assign acc_add = acc
                 + {{(SUM_W-2*N_W){1'b0}}, sq};

  // Both asking: pri breaks the tie.
  assign gnt_id = (&req) ? pri : req[1];
  assign last   = (count == n_lat);
  assign busy   = (state == RUN);

  always_comb begin
    state_nx   = state;
    pri_nx     = pri;
    id_nx      = id_lat;
    n_nx       = n_lat;
    count_nx   = count;
    acc_nx     = acc;
    sum_nx     = sum;
    ack_nx     = 2'b00;
    done_nx    = 1'b0;
    done_id_nx = done_id;
    unique case (state)
      IDLE: begin
        if (|req) begin
          state_nx = RUN;
          id_nx    = gnt_id;
          n_nx     = gnt_id ? n1 : n0;
          count_nx = N_W'(1);
          acc_nx   = '0;
          ack_nx   = gnt_id ? 2'b10 : 2'b01;
        end
      end
      RUN: begin
        if (kill) begin
          state_nx = IDLE;
          pri_nx   = ~id_lat;
          count_nx = '0;
          acc_nx   = '0;
        end else if (n_lat == '0 || last) begin
          state_nx   = IDLE;
          sum_nx     = (n_lat == '0) ? '0 : acc_add;
          done_nx    = 1'b1;
          done_id_nx = id_lat;
          pri_nx     = ~id_lat;
          count_nx   = '0;
          acc_nx     = '0;
        end else begin
          acc_nx   = acc_add;
          count_nx = count + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pri     <= 1'b0;
      id_lat  <= 1'b0;
      n_lat   <= '0;
      count   <= '0;
      acc     <= '0;
      sum     <= '0;
      ack     <= 2'b00;
      done    <= 1'b0;
      done_id <= 1'b0;
    end else begin
      state   <= state_nx;
      pri     <= pri_nx;
      id_lat  <= id_nx;
      n_lat   <= n_nx;
      count   <= count_nx;
      acc     <= acc_nx;
      sum     <= sum_nx;
      ack     <= ack_nx;
      done    <= done_nx;
      done_id <= done_id_nx;
    end
  end

endmodule

// File: tb/tb_sum_sq_sched.sv
// tb_sum_sq_sched: directed checks of sum_sq_sched.
// Define SUM_SQ_SCHED_ABORT_EN to also exercise abort.
module tb_sum_sq_sched;

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [3:0]  n0;
  logic [3:0]  n1;
  logic        abort;
  logic [1:0]  ack;
  logic        busy;
  logic        done;
  logic        done_id;
  logic [10:0] sum;

  int n_chk;
  int n_fail;

  sum_sq_sched #(
    .N_W   (4),
    .SUM_W (11)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .n0      (n0),
    .n1      (n1),
`ifdef SUM_SQ_SCHED_ABORT_EN
    .abort   (abort),
`endif
    .ack     (ack),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .sum     (sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    req   = 2'b00;
    abort = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_idle(input string tag, input int s);
    chk({tag, "_ack"},  ack, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_sum"},  sum, s);
  endtask

  task automatic job(
    input int       id,
    input logic [3:0] n,
    input int       exp
  );
    int lat;
    lat = (n == 4'd0) ? 1 : int'(n);
    if (id == 0) n0 = n;
    else n1 = n;
    req[id] = 1'b1;
    tick();
    chk("ack_c0", ack, (id != 0) ? 2 : 1);
    chk("busy_c0", busy, 1);
    req = 2'b00;
    if (id == 0) n0 = ~n;
    else n1 = ~n;
    for (int k = 1; k <= lat; k++) begin
      tick();
      if (k < lat) begin
        chk("run_done", done, 0);
        chk("run_busy", busy, 1);
      end
    end
    chk("done", done, 1);
    chk("done_id", done_id, id);
    chk("sum", sum, exp);
    chk("busy_end", busy, 0);
    tick();
    chk("done_pulse", done, 0);
    chk("sum_hold", sum, exp);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    req    = 2'b00;
    n0     = 4'd0;
    n1     = 4'd0;
    abort  = 1'b0;
    @(negedge clk);

    // reset and quiet period
    do_reset();
    chk("rst_done_id", done_id, 0);
    for (int i = 0; i < 10; i++) begin
      chk_idle("rst", 0);
      tick();
    end

    // single jobs, operand flipped after ack
    job(0, 4'd2, 5);
    job(0, 4'd15, 1240);
    job(1, 4'd0, 0);

    // contention from reset
    do_reset();
    n0  = 4'd4;
    n1  = 4'd3;
    req = 2'b11;
    tick();
    chk("ct_ack0", ack, 1);
    req = 2'b10;
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("ct_run0", done, 0);
    end
    tick();
    chk("ct_done0", done, 1);
    chk("ct_id0", done_id, 0);
    chk("ct_sum0", sum, 30);
    chk("ct_noack", ack, 0);
    tick();
    chk("ct_ack1", ack, 2);
    chk("ct_busy1", busy, 1);
    req = 2'b00;
    tick();
    chk("ct_run1a", done, 0);
    tick();
    chk("ct_run1b", done, 0);
    tick();
    chk("ct_done1", done, 1);
    chk("ct_id1", done_id, 1);
    chk("ct_sum1", sum, 14);

    // fairness: req0 held throughout
    do_reset();
    n0  = 4'd1;
    req = 2'b01;
    tick();
    chk("fr_ack0", ack, 1);
    n1  = 4'd2;
    req = 2'b11;
    tick();
    chk("fr_done0", done, 1);
    chk("fr_id0", done_id, 0);
    chk("fr_sum0", sum, 1);
    tick();
    chk("fr_ack1", ack, 2);
    req = 2'b01;
    tick();
    chk("fr_run1", done, 0);
    tick();
    chk("fr_done1", done, 1);
    chk("fr_id1", done_id, 1);
    chk("fr_sum1", sum, 5);
    tick();
    chk("fr_ack2", ack, 1);
    req = 2'b00;
    tick();
    chk("fr_done2", done, 1);
    chk("fr_id2", done_id, 0);

    // reset in the middle of a job
    job(0, 4'd2, 5);
    n0  = 4'd9;
    req = 2'b01;
    tick();
    chk("mr_ack", ack, 1);
    req = 2'b00;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk_idle("mr", 0);
    chk("mr_done_id", done_id, 0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("mr_nodone", done, 0);
    end

`ifdef SUM_SQ_SCHED_ABORT_EN
    // abort mid-run, pending req1 served next
    job(0, 4'd2, 5);
    n0  = 4'd10;
    req = 2'b01;
    tick();
    chk("ab_ack0", ack, 1);
    n1  = 4'd1;
    req = 2'b10;
    tick();
    tick();
    tick();
    chk("ab_run", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_idle("ab", 5);
    tick();
    chk("ab_ack1", ack, 2);
    chk("ab_busy1", busy, 1);
    req = 2'b00;
    tick();
    chk("ab_done1", done, 1);
    chk("ab_id1", done_id, 1);
    chk("ab_sum1", sum, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
